data_cache_ctrl: RTL

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_way.sv | 61 ++++++
 rtl/data_cache_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WTHRU = 2'd2,
    WDONE = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_SETS          = 8;

  // Index bits sit just above the byte offset; tag takes the rest.
  function automatic int unsigned calc_index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned aw, input int unsigned sets);
    return aw - $clog2(sets) - 2;
  endfunction

  localparam int unsigned INDEX_W = calc_index_w(DEF_SETS);
  localparam int unsigned TAG_W   = calc_tag_w(DEF_ADDRESS_WIDTH, DEF_SETS);

  // Performance counters stop at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid bits, tags and data words with combinational read.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned IDX_W      = INDEX_W,
  parameter int unsigned TG_W       = TAG_W,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  fill_i,
  input  logic                  wr_i,
  input  logic [IDX_W-1:0]      index_i,
  input  logic [TG_W-1:0]       tag_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_valid_o,
  output logic [TG_W-1:0]       rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TG_W-1:0]       tag_q  [SETS];
  logic [TG_W-1:0]       tag_d  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] data_d [SETS];

  // Next contents: flush clears valids, fill installs a line, store updates data.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (fill_i) begin
      valid_d[index_i] = 1'b1;
      tag_d[index_i]   = tag_i;
    end
    if (fill_i || wr_i) begin
      data_d[index_i] = data_i;
    end
  end

  // Valid bits are the only reset state in the way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid_o = valid_q[index_i];
  assign rd_tag_o   = tag_q[index_i];
  assign rd_data_o  = data_q[index_i];

endmodule

// File: rtl/data_cache_ctrl.sv
// Write-through, no-write-allocate data cache controller for the memory stage.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETS          = 8,
  parameter int unsigned WAYS          = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     stall,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int unsigned IDX_W = calc_index_w(SETS);
  localparam int unsigned TG_W  = calc_tag_w(ADDRESS_WIDTH, SETS);

  state_e                  state_q, state_d;
  logic [SETS-1:0]         lru_q, lru_d;
  logic [31:0]             hit_count_q, hit_count_d;
  logic [31:0]             miss_count_q, miss_count_d;
  logic                    wr_hit_q, wr_hit_d;
  logic                    wr_way_q, wr_way_d;

  logic [IDX_W-1:0]        index;
  logic [TG_W-1:0]         tag;
  logic [1:0]              unused_addr_lsb;
  logic [WAYS-1:0]         way_valid, way_hit, fill_en, wr_en;
  logic [TG_W-1:0]         way_tag  [WAYS];
  logic [DATA_WIDTH-1:0]   way_data [WAYS];
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    flush_ways, hit, hit_way, victim;
  logic                    stall_c, mem_req_c, mem_we_c;
  logic [DATA_WIDTH-1:0]   rdata_c, mem_wdata_c;
  logic [ADDRESS_WIDTH-1:0] mem_addr_c;

  assign index           = req_addr[IDX_W+1:2];
  assign tag             = req_addr[ADDRESS_WIDTH-1:IDX_W+2];
  assign unused_addr_lsb = req_addr[1:0];

  // Storage and tag compare for each way.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .SETS       (SETS),
      .IDX_W      (IDX_W),
      .TG_W       (TG_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_ways),
      .fill_i     (fill_en[w]),
      .wr_i       (wr_en[w]),
      .index_i    (index),
      .tag_i      (tag),
      .data_i     (wr_data),
      .rd_valid_o (way_valid[w]),
      .rd_tag_o   (way_tag[w]),
      .rd_data_o  (way_data[w])
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == tag);
  end

  // Hit detection and fill victim: an invalid way first (way 0 first), else the LRU way.
  always_comb begin
    hit     = |way_hit;
    hit_way = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = 1'(w);
    end
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!way_valid[0])           victim = 1'b0;
      else if (!way_valid[WAYS-1]) victim = 1'b1;
      else                         victim = lru_q[index];
    end
  end

  // Next state, LRU/counter updates and combinational outputs.
  always_comb begin
    state_d      = state_q;
    lru_d        = lru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wr_hit_d     = wr_hit_q;
    wr_way_d     = wr_way_q;
    stall_c      = 1'b0;
    rdata_c      = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    flush_ways   = 1'b0;
    fill_en      = '0;
    wr_en        = '0;
    wr_data      = '0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          flush_ways = 1'b1;
          lru_d      = '0;
          stall_c    = req_valid;
        end else if (req_valid && !req_we) begin
          if (hit) begin
            rdata_c        = way_data[hit_way];
            lru_d[index]   = ~hit_way;
            hit_count_d    = sat_inc(hit_count_q);
          end else begin
            stall_c      = 1'b1;
            miss_count_d = sat_inc(miss_count_q);
            state_d      = RMISS;
          end
        end else if (req_valid) begin
          stall_c  = 1'b1;
          wr_hit_d = hit;
          wr_way_d = hit_way;
          if (hit) hit_count_d  = sat_inc(hit_count_q);
          else     miss_count_d = sat_inc(miss_count_q);
          state_d  = WTHRU;
        end
      end
      RMISS: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
        if (mem_ack) begin
          fill_en[victim] = 1'b1;
          wr_data         = mem_rdata;
          lru_d[index]    = ~victim;
          state_d         = IDLE;
        end
      end
      WTHRU: begin
        stall_c     = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
        mem_wdata_c = req_wdata;
        if (mem_ack) begin
          if (wr_hit_q) wr_en[wr_way_q] = 1'b1;
          wr_data = req_wdata;
          state_d = WDONE;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, LRU, counters and captured store lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wr_hit_q     <= 1'b0;
      wr_way_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wr_hit_q     <= wr_hit_d;
      wr_way_q     <= wr_way_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign stall      = rst & stall_c;
  assign rdata      = rst ? rdata_c     : '0;
  assign mem_req    = rst & mem_req_c;
  assign mem_we     = rst & mem_we_c;
  assign mem_addr   = rst ? mem_addr_c  : '0;
  assign mem_wdata  = rst ? mem_wdata_c : '0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
